// File: rtl/vt52_pkg.sv
// vt52_pkg: shared constants and types for the VT52 terminal character path.
//   ADDR_BITS   : character buffer address width
//   COLUMNS/ROWS: screen geometry; BUFFER_SIZE is the number of valid cells
//   arb_state_t : write-port arbiter states
package vt52_pkg;

    localparam int ADDR_BITS   = 11;
    localparam int COLUMNS     = 80;
    localparam int ROWS        = 24;
    localparam int BUFFER_SIZE = COLUMNS * ROWS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/char_buffer_arbiter_if.sv
// char_buffer_arbiter_if: bundles the requester handshakes and the char
// buffer write port around the arbiter.
//   wr_*        : single-character write request (valid/ready)
//   fill_*      : fill request (valid/ready), start cell and length
//   busy        : fill in progress
//   fill_done   : pulse with the last write of a fill
//   new_char*   : char buffer write port
// Modports: slave = the arbiter, master = requesters + char buffer side.
interface char_buffer_arbiter_if #(
    parameter int ADDR_BITS = vt52_pkg::ADDR_BITS
);
    logic [7:0]           wr_char;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [7:0]           fill_char;
    logic [ADDR_BITS-1:0] fill_start;
    logic [ADDR_BITS:0]   fill_len;
    logic                 fill_valid;
    logic                 fill_ready;
    logic                 busy;
    logic                 fill_done;
    logic [7:0]           new_char;
    logic [ADDR_BITS-1:0] new_char_address;
    logic                 new_char_wen;

    modport slave (
        input  wr_char, wr_addr, wr_valid,
        input  fill_char, fill_start, fill_len, fill_valid,
        output wr_ready, fill_ready, busy, fill_done,
        output new_char, new_char_address, new_char_wen
    );

    modport master (
        output wr_char, wr_addr, wr_valid,
        output fill_char, fill_start, fill_len, fill_valid,
        input  wr_ready, fill_ready, busy, fill_done,
        input  new_char, new_char_address, new_char_wen
    );
endinterface

// File: rtl/buffer_addr_counter.sv
// buffer_addr_counter: address register with modulo-BUFFER_SIZE increment and
// a remaining-length down-counter for the fill engine.
//   i_clk, i_reset : clock, async active-high reset
//   i_load         : load i_start/i_len (i_start already < BUFFER_SIZE)
//   i_inc          : one write issued; advance address, decrement count
//   i_start, i_len : first cell of the fill, number of cells (>= 1)
//   o_addr         : address of the next write after the one on the bus
//   o_last        : the write currently on the bus is the final one
module buffer_addr_counter #(
    parameter int ADDR_BITS   = vt52_pkg::ADDR_BITS,
    parameter int BUFFER_SIZE = vt52_pkg::BUFFER_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_inc,
    input  logic [ADDR_BITS-1:0] i_start,
    input  logic [ADDR_BITS:0]   i_len,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic                 o_last
);
    localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(BUFFER_SIZE - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   LEN_ONE   = (ADDR_BITS + 1)'(1);

    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS:0]   r_cnt;

    // Wrap at the buffer size, which is not a power of two.
    function automatic logic [ADDR_BITS-1:0] wrap_inc(input logic [ADDR_BITS-1:0] a);
        return (a == LAST_CELL) ? '0 : a + ADDR_ONE;
    endfunction

    // The first cell is driven straight onto the output register at
    // acceptance, so the address register starts one cell ahead.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= wrap_inc(i_start);
            r_cnt  <= i_len;
        end else if (i_inc) begin
            r_addr <= wrap_inc(r_addr);
            r_cnt  <= r_cnt - LEN_ONE;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == LEN_ONE);

endmodule

// File: rtl/char_buffer_arbiter.sv
// char_buffer_arbiter: owns the char buffer write port and shares it between
// single-character writes and a fill engine (wrapping, circular buffer).
//   clk   : VGA clock
//   reset : async active-high; aborts any fill in progress
//   bus   : char_buffer_arbiter_if slave (requests, readies, status,
//           registered char buffer write port)
module char_buffer_arbiter
    import vt52_pkg::*;
#(
    parameter int ADDR_BITS   = vt52_pkg::ADDR_BITS,
    parameter int BUFFER_SIZE = vt52_pkg::BUFFER_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    char_buffer_arbiter_if.slave  bus
);
    localparam logic [ADDR_BITS:0]   SIZE_LEN  = (ADDR_BITS + 1)'(BUFFER_SIZE);
    localparam logic [ADDR_BITS-1:0] SIZE_ADDR = ADDR_BITS'(BUFFER_SIZE);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [7:0]           r_char;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_wen;

    logic                 w_wr_accept;
    logic                 w_fill_accept;
    logic                 w_load;
    logic                 w_inc;
    logic [ADDR_BITS-1:0] w_fill_addr;
    logic [ADDR_BITS:0]   w_fill_len;
    logic [ADDR_BITS-1:0] w_cnt_addr;
    logic                 w_last;

    // A start beyond the buffer folds back once; BUFFER_SIZE > 2^ADDR_BITS/2
    // guarantees a single subtraction is enough.
    assign w_fill_addr = ({1'b0, bus.fill_start} < SIZE_LEN) ? bus.fill_start
                                                             : bus.fill_start - SIZE_ADDR;
    assign w_fill_len  = (bus.fill_len > SIZE_LEN) ? SIZE_LEN : bus.fill_len;

    // Single writes win a same-cycle tie; the fill simply stays pending.
    assign bus.wr_ready   = (r_state == IDLE);
    assign bus.fill_ready = (r_state == IDLE) && !bus.wr_valid;
    assign w_wr_accept    = bus.wr_valid && bus.wr_ready;
    assign w_fill_accept  = bus.fill_valid && bus.fill_ready;

    assign bus.busy      = (r_state == FILL);
    assign bus.fill_done = (r_state == FILL) && w_last;

    buffer_addr_counter #(
        .ADDR_BITS   (ADDR_BITS),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_counter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_load),
        .i_inc   (w_inc),
        .i_start (w_fill_addr),
        .i_len   (w_fill_len),
        .o_addr  (w_cnt_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            IDLE: begin
                // A zero-length fill is consumed without any effect.
                if (w_fill_accept && (w_fill_len != '0)) begin
                    w_load       = 1'b1;
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_inc = 1'b1;
                if (w_last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Write port registers. During a fill r_char keeps the fill character
    // loaded at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_char <= '0;
            r_addr <= '0;
            r_wen  <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (r_state == IDLE) begin
                if (w_wr_accept) begin
                    r_char <= bus.wr_char;
                    r_addr <= bus.wr_addr;
                    r_wen  <= 1'b1;
                end else if (w_load) begin
                    r_char <= bus.fill_char;
                    r_addr <= w_fill_addr;
                    r_wen  <= 1'b1;
                end
            end else if (!w_last) begin
                r_addr <= w_cnt_addr;
                r_wen  <= 1'b1;
            end
        end
    end

    assign bus.new_char         = r_char;
    assign bus.new_char_address = r_addr;
    assign bus.new_char_wen     = r_wen;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// tb_char_buffer_arbiter: table-driven cycle vectors for handshakes and short
// fills, plus hand-written sequences for long, wrapping, clamped and
// reset-aborted fills.
module tb_char_buffer_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    char_buffer_arbiter_if #(.ADDR_BITS(11)) bus ();

    char_buffer_arbiter #(.ADDR_BITS(11), .BUFFER_SIZE(1920)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [7:0]  wc;
        logic [10:0] wa;
        logic        fv;
        logic [7:0]  fc;
        logic [10:0] fs;
        logic [11:0] fl;
        logic        e_wen;
        logic [10:0] e_addr;
        logic [7:0]  e_char;
        logic        e_wrdy;
        logic        e_frdy;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t v(
        input logic wv, input logic [7:0] wc, input logic [10:0] wa,
        input logic fv, input logic [7:0] fc, input logic [10:0] fs, input logic [11:0] fl,
        input logic ew, input logic [10:0] ea, input logic [7:0] ec,
        input logic wr, input logic fr, input logic b, input logic d);
        vec_t r;
        r.wv = wv; r.wc = wc; r.wa = wa;
        r.fv = fv; r.fc = fc; r.fs = fs; r.fl = fl;
        r.e_wen = ew; r.e_addr = ea; r.e_char = ec;
        r.e_wrdy = wr; r.e_frdy = fr; r.e_busy = b; r.e_done = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pack_outputs();
        return {bus.new_char_wen, bus.new_char_address, bus.new_char,
                bus.wr_ready, bus.fill_ready, bus.busy, bus.fill_done};
    endfunction

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_char    = '0;
        bus.wr_addr    = '0;
        bus.fill_valid = 1'b0;
        bus.fill_char  = '0;
        bus.fill_start = '0;
        bus.fill_len   = '0;
    endtask

    // Presents one fill at a negedge, then watches the write port for the
    // expected number of writes against an independent address model.
    task automatic run_fill(input string name, input logic [10:0] st, input logic [11:0] ln,
                            input logic [7:0] ch, input int exp_n, input logic [10:0] exp_first);
        int          n_wr;
        int          bad_wr;
        int          bad_done;
        int          bad_busy;
        logic [10:0] ea;
        n_wr = 0; bad_wr = 0; bad_done = 0; bad_busy = 0;
        ea = exp_first;
        @(negedge clk);
        bus.fill_valid = 1'b1;
        bus.fill_char  = ch;
        bus.fill_start = st;
        bus.fill_len   = ln;
        #1;
        check({name, "_accept"}, {31'd0, bus.fill_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < exp_n + 4; k++) begin
            #1;
            if (bus.busy !== bus.new_char_wen) bad_busy++;
            if (bus.new_char_wen === 1'b1) begin
                if (bus.new_char_address !== ea || bus.new_char !== ch) begin
                    bad_wr++;
                    if (bad_wr == 1)
                        $display("FAIL %s_first_bad_write: got %h/%h expected %h/%h",
                                 name, bus.new_char_address, bus.new_char, ea, ch);
                end
                if (bus.fill_done !== (n_wr == exp_n - 1)) bad_done++;
                n_wr++;
                ea = (ea == 11'd1919) ? 11'd0 : ea + 11'd1;
            end else if (bus.fill_done !== 1'b0) begin
                bad_done++;
            end
            @(negedge clk);
        end
        check({name, "_write_count"}, n_wr, exp_n);
        check({name, "_bad_writes"}, bad_wr, 0);
        check({name, "_done_errors"}, bad_done, 0);
        check({name, "_busy_errors"}, bad_busy, 0);
        #1;
        check({name, "_idle_after"}, {28'd0, bus.wr_ready, bus.fill_ready, bus.busy, bus.fill_done},
              {28'd0, 4'b1100});
    endtask

    initial begin
        int n_wr;
        int stray;
        logic seen;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 0, 11'h000, 8'h00, 1, 1, 0, 0);
        vecs[1]  = v(1, 8'h41, 11'h005, 0, 8'h00, 11'h000, 12'd0, 0, 11'h000, 8'h00, 1, 0, 0, 0);
        vecs[2]  = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 1, 11'h005, 8'h41, 1, 1, 0, 0);
        vecs[3]  = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 0, 11'h005, 8'h41, 1, 1, 0, 0);
        vecs[4]  = v(1, 8'h42, 11'h010, 1, 8'h2E, 11'h100, 12'd3, 0, 11'h005, 8'h41, 1, 0, 0, 0);
        vecs[5]  = v(0, 8'h00, 11'h000, 1, 8'h2E, 11'h100, 12'd3, 1, 11'h010, 8'h42, 1, 1, 0, 0);
        vecs[6]  = v(1, 8'h43, 11'h020, 0, 8'h00, 11'h000, 12'd0, 1, 11'h100, 8'h2E, 0, 0, 1, 0);
        vecs[7]  = v(1, 8'h43, 11'h020, 0, 8'h00, 11'h000, 12'd0, 1, 11'h101, 8'h2E, 0, 0, 1, 0);
        vecs[8]  = v(1, 8'h43, 11'h020, 0, 8'h00, 11'h000, 12'd0, 1, 11'h102, 8'h2E, 0, 0, 1, 1);
        vecs[9]  = v(1, 8'h43, 11'h020, 0, 8'h00, 11'h000, 12'd0, 0, 11'h102, 8'h2E, 1, 0, 0, 0);
        vecs[10] = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 1, 11'h020, 8'h43, 1, 1, 0, 0);
        vecs[11] = v(0, 8'h00, 11'h000, 1, 8'h55, 11'h007, 12'd0, 0, 11'h020, 8'h43, 1, 1, 0, 0);
        vecs[12] = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 0, 11'h020, 8'h43, 1, 1, 0, 0);
        vecs[13] = v(0, 8'h00, 11'h000, 1, 8'h58, 11'd2000, 12'd2, 0, 11'h020, 8'h43, 1, 1, 0, 0);
        vecs[14] = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 1, 11'd80, 8'h58, 0, 0, 1, 0);
        vecs[15] = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 1, 11'd81, 8'h58, 0, 0, 1, 1);
        vecs[16] = v(0, 8'h00, 11'h000, 0, 8'h00, 11'h000, 12'd0, 0, 11'd81, 8'h58, 1, 1, 0, 0);

        // Reset state, sampled while reset is still high.
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {8'd0, pack_outputs()}, {8'd0, 1'b0, 11'h000, 8'h00, 4'b1100});
        @(negedge clk);
        reset = 1'b0;

        // Vector table: inputs for cycle i, outputs expected in cycle i.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.wr_valid   = vecs[i].wv;
            bus.wr_char    = vecs[i].wc;
            bus.wr_addr    = vecs[i].wa;
            bus.fill_valid = vecs[i].fv;
            bus.fill_char  = vecs[i].fc;
            bus.fill_start = vecs[i].fs;
            bus.fill_len   = vecs[i].fl;
            #1;
            check($sformatf("vec%0d", i), {8'd0, pack_outputs()},
                  {8'd0, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_char,
                   vecs[i].e_wrdy, vecs[i].e_frdy, vecs[i].e_busy, vecs[i].e_done});
        end
        idle_inputs();

        // Whole-screen clear, wrapping fill, and an over-long clamped fill.
        run_fill("clear_screen", 11'd0, 12'd1920, 8'h20, 1920, 11'd0);
        run_fill("wrap_fill", 11'd1900, 12'd40, 8'h2D, 40, 11'd1900);
        run_fill("clamp_fill", 11'd0, 12'd3000, 8'h2A, 1920, 11'd0);

        // Reset asserted at the 10th write of a 100-cell fill.
        @(negedge clk);
        bus.fill_valid = 1'b1;
        bus.fill_char  = 8'h23;
        bus.fill_start = 11'd500;
        bus.fill_len   = 12'd100;
        @(negedge clk);
        idle_inputs();
        n_wr = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (bus.new_char_wen === 1'b1) n_wr++;
            if (n_wr == 10) begin
                seen = 1'b1;
                check("abort_10th_addr", {21'd0, bus.new_char_address}, 32'd509);
                reset = 1'b1;
                #1;
                check("abort_wen_drops", {31'd0, bus.new_char_wen}, 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        check("abort_reached_10th", {31'd0, seen}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            #1;
            if (bus.new_char_wen !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        check("abort_no_further_writes", stray, 0);
        check("abort_idle_readies", {28'd0, bus.wr_ready, bus.fill_ready, bus.busy, bus.fill_done},
              {28'd0, 4'b1100});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
